// File: rtl/axi_rd_burst_gen.sv
// rtl/axi_rd_burst_gen.sv - AXI read burst to per-beat memory reads, packed R beats out
// One burst and one memory read in flight; beat output is held in registers until taken.
module axi_rd_burst_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_BITS    = 4,
  parameter int LEN_BITS   = 8,
  parameter int SIZE_BITS  = 3
) (
  input  logic                                               clk_i,
  input  logic                                               rst_i,
  input  logic                                               ar_valid_i,
  output logic                                               ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]                              ar_addr_i,
  input  logic [LEN_BITS-1:0]                                ar_len_i,
  input  logic [SIZE_BITS-1:0]                               ar_size_i,
  input  logic [1:0]                                         ar_burst_i,
  input  logic [ID_BITS-1:0]                                 ar_id_i,
  output logic                                               mem_req_o,
  output logic [ADDR_WIDTH-1:0]                              mem_addr_o,
  output logic [SIZE_BITS-1:0]                               mem_size_o,
  input  logic                                               mem_gnt_i,
  input  logic                                               mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                              mem_rdata_i,
  input  logic                                               mem_err_i,
  output logic                                               valid_o,
  input  logic                                               ready_i,
  output logic [DATA_WIDTH+2+SIZE_BITS+LEN_BITS+ID_BITS-1:0] data_o,
  output logic                                               last_o
);

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, ERR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_BITS-1:0]   rem_q;
  logic [SIZE_BITS-1:0]  size_q;
  logic [1:0]            burst_q;
  logic [ID_BITS-1:0]    id_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;
  logic                  ar_legal;
  logic                  beat_hs;
  logic                  rem_zero;

  // Only FIXED/INCR with a beat no wider than the data bus are serviced from memory.
  assign ar_legal = ((ar_burst_i == 2'b00) || (ar_burst_i == 2'b01)) &&
                    (int'(ar_size_i) <= MAX_SIZE);
  assign rem_zero = (rem_q == '0);
  assign beat_hs  = valid_o && ready_i;

  assign mem_addr_o = addr_q;
  assign mem_size_o = size_q;
  assign data_o     = {rdata_q, resp_q, size_q, rem_q, id_q};
  assign last_o     = valid_o && rem_zero;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ar_ready_o = 1'b0;
    mem_req_o  = 1'b0;
    valid_o    = 1'b0;
    case (state_q)
      IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) state_d = ar_legal ? REQ : ERR;
      end
      REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i) state_d = SEND;
      end
      SEND: begin
        valid_o = 1'b1;
        if (ready_i) state_d = rem_zero ? IDLE : REQ;
      end
      ERR: begin
        valid_o = 1'b1;
        if (ready_i && rem_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      rem_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_valid_i) begin
            addr_q  <= ar_addr_i;
            rem_q   <= ar_len_i;
            size_q  <= ar_size_i;
            burst_q <= ar_burst_i;
            id_q    <= ar_id_i;
            rdata_q <= '0;
            resp_q  <= ar_legal ? 2'b00 : 2'b10;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            rdata_q <= mem_rdata_i;
            resp_q  <= mem_err_i ? 2'b10 : 2'b00;
          end
        end
        SEND: begin
          if (beat_hs && !rem_zero) begin
            rem_q <= rem_q - LEN_BITS'(1);
            if (burst_q == 2'b01) addr_q <= addr_q + (ADDR_WIDTH'(1) << size_q);
          end
        end
        ERR: begin
          if (beat_hs && !rem_zero) rem_q <= rem_q - LEN_BITS'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_gen.sv
// tb/tb_axi_rd_burst_gen.sv - directed self-checking bench for axi_rd_burst_gen
module tb_axi_rd_burst_gen;

  localparam int DW = 32;
  localparam int OW = DW + 2 + 3 + 8 + 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          ar_valid_i;
  logic          ar_ready_o;
  logic [31:0]   ar_addr_i;
  logic [7:0]    ar_len_i;
  logic [2:0]    ar_size_i;
  logic [1:0]    ar_burst_i;
  logic [3:0]    ar_id_i;
  logic          mem_req_o;
  logic [31:0]   mem_addr_o;
  logic [2:0]    mem_size_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [31:0]   mem_rdata_i;
  logic          mem_err_i;
  logic          valid_o;
  logic          ready_i;
  logic [OW-1:0] data_o;
  logic          last_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  axi_rd_burst_gen dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i), .ar_id_i(ar_id_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_size_o(mem_size_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_err_i(mem_err_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .last_o(last_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drives one AR and acts as a latency-1 memory that always grants immediately.
  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [3:0] id, input int stall_beat, input int err_beat);
    logic          legal;
    logic          gnt_prev;
    logic          stalled_prev;
    logic          done;
    logic [31:0]   granted;
    logic [31:0]   e_addr;
    logic [OW-1:0] held;
    int            nb, nreq, rv_idx, stall_cnt, overlap, budget;
    legal = (burst <= 2'b01) && (size <= 3'd2);
    gnt_prev = 1'b0; stalled_prev = 1'b0; done = 1'b0; granted = '0; held = '0;
    nb = 0; nreq = 0; rv_idx = 0; stall_cnt = 0; overlap = 0;
    budget = 4 * (int'(len) + 1) + 20;
    chk("ar_ready_idle", 64'(ar_ready_o), 64'd1);
    ar_valid_i = 1'b1; ar_addr_i = addr; ar_len_i = len;
    ar_size_i = size; ar_burst_i = burst; ar_id_i = id;
    @(negedge clk_i);
    ar_valid_i = 1'b0;
    chk("req_latency", 64'(mem_req_o), 64'(legal));
    chk("ar_ready_busy", 64'(ar_ready_o), 64'd0);
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      if (mem_req_o && valid_o) overlap++;
      if (mem_req_o) begin
        e_addr = (burst == 2'b00) ? addr : addr + (32'(nreq) << size);
        if (nreq <= int'(len)) chk("mem_addr", 64'(mem_addr_o), 64'(e_addr));
        nreq++;
      end
      if (stalled_prev) begin
        chk("stall_valid", 64'(valid_o), 64'd1);
        chk("stall_data", 64'(data_o), 64'(held));
      end
      mem_rvalid_i = gnt_prev;
      mem_rdata_i  = granted ^ 32'h5A5A_0000;
      mem_err_i    = gnt_prev && (rv_idx == err_beat);
      if (gnt_prev) rv_idx++;
      gnt_prev  = mem_req_o;
      if (mem_req_o) granted = mem_addr_o;
      mem_gnt_i = mem_req_o;
      if (valid_o && nb == stall_beat && stall_cnt < 3) begin
        ready_i = 1'b0;
        stall_cnt++;
      end else begin
        ready_i = 1'b1;
      end
      stalled_prev = valid_o && !ready_i;
      held = data_o;
      if (valid_o && ready_i) begin
        e_addr = (burst == 2'b00) ? addr : addr + (32'(nb) << size);
        chk("beat_rdata", 64'(data_o[OW-1 -: DW]),
            legal ? 64'(e_addr ^ 32'h5A5A_0000) : 64'd0);
        chk("beat_resp", 64'(data_o[16:15]),
            (!legal || nb == err_beat) ? 64'd2 : 64'd0);
        chk("beat_size", 64'(data_o[14:12]), 64'(size));
        chk("beat_rem", 64'(data_o[11:4]), 64'(int'(len) - nb));
        chk("beat_id", 64'(data_o[3:0]), 64'(id));
        chk("beat_last", 64'(last_o), 64'(nb == int'(len)));
        if (nb == int'(len)) done = 1'b1;
        nb++;
      end
      @(negedge clk_i);
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; ready_i = 1'b0;
    chk("burst_done", 64'(done), 64'd1);
    chk("beat_count", 64'(nb), 64'(int'(len) + 1));
    chk("req_count", 64'(nreq), legal ? 64'(int'(len) + 1) : 64'd0);
    chk("req_during_beat", 64'(overlap), 64'd0);
    chk("idle_valid", 64'(valid_o), 64'd0);
    chk("idle_ar_ready", 64'(ar_ready_o), 64'd1);
  endtask

  initial begin
    rst_i = 1'b1; ar_valid_i = 1'b0; ar_addr_i = '0; ar_len_i = '0; ar_size_i = '0;
    ar_burst_i = '0; ar_id_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i = '0; mem_err_i = 1'b0; ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_ar_ready", 64'(ar_ready_o), 64'd1);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_last", 64'(last_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);

    run_burst(32'h0000_0100, 8'd3, 3'd2, 2'b01, 4'h5, -1, -1);
    run_burst(32'h0000_0100, 8'd3, 3'd2, 2'b01, 4'h6, 2, -1);
    run_burst(32'h0000_0040, 8'd2, 3'd2, 2'b00, 4'hA, -1, -1);
    run_burst(32'h0000_0200, 8'd2, 3'd2, 2'b01, 4'h3, -1, 1);
    run_burst(32'h0000_0300, 8'd1, 3'd2, 2'b10, 4'h7, -1, -1);
    run_burst(32'h0000_0300, 8'd1, 3'd3, 2'b01, 4'h8, 0, -1);
    run_burst(32'h0000_0080, 8'd0, 3'd1, 2'b01, 4'h1, -1, -1);
    run_burst(32'hFFFF_FFF0, 8'd255, 3'd0, 2'b01, 4'hF, -1, -1);

    // Reset while waiting on memory; the late response must not surface as a beat.
    ar_valid_i = 1'b1; ar_addr_i = 32'h500; ar_len_i = 8'd3; ar_size_i = 3'd2;
    ar_burst_i = 2'b01; ar_id_i = 4'h2;
    @(negedge clk_i);
    ar_valid_i = 1'b0;
    chk("t6_req", 64'(mem_req_o), 64'd1);
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    chk("t6_wait_noreq", 64'(mem_req_o), 64'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("t6_rst_valid", 64'(valid_o), 64'd0);
    chk("t6_rst_ar_ready", 64'(ar_ready_o), 64'd1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    chk("t6_stale_valid", 64'(valid_o), 64'd0);
    chk("t6_stale_ar_ready", 64'(ar_ready_o), 64'd1);
    chk("t6_stale_req", 64'(mem_req_o), 64'd0);
    run_burst(32'h0000_0600, 8'd1, 3'd2, 2'b01, 4'h9, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
